// File: rtl/pc_sequencer.sv
// Program-counter stage: next-PC selection, run-control FSM (BOOT/RUN/HALT/TRAP).
// Optional taken-transfer counter enabled by defining PC_PERF_CNT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchvalid,
  input  logic        jump,
  input  logic        jalr,
  input  logic        halt_req,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        trap,
  output logic [31:0] bad_addr,
  output logic        halted,
  output logic [31:0] taken_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, TRAP} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] bad_addr_reg;
  logic        redirect_reg;
  logic        trap_reg;
  logic        halted_reg;

  logic [31:0] target_next;
  logic        take_next;
  logic        misaligned_next;
  logic        commit_next;

  assign pc_plus4 = pc_reg + 32'd4;

  // jalr > jump > branchvalid; the sequential path never reaches the alignment check.
  always_comb begin
    target_next = pc_reg + imm;
    take_next   = 1'b0;
    if (jalr) begin
      target_next = (rs1_data + imm) & ~32'h1;
      take_next   = 1'b1;
    end else if (jump || branchvalid) begin
      target_next = pc_reg + imm;
      take_next   = 1'b1;
    end
  end

  assign misaligned_next = take_next && (target_next[1:0] != 2'b00);
  assign commit_next     = (state_reg == RUN) && !halt_req && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_VECTOR;
      bad_addr_reg <= 32'h0;
      redirect_reg <= 1'b0;
      trap_reg     <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      redirect_reg <= 1'b0;
      trap_reg     <= 1'b0;
      case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          if (halt_req) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else if (!stall) begin
            if (misaligned_next) begin
              pc_reg       <= TRAP_VECTOR;
              bad_addr_reg <= target_next;
              trap_reg     <= 1'b1;
              state_reg    <= TRAP;
            end else if (take_next) begin
              pc_reg       <= target_next;
              redirect_reg <= 1'b1;
            end else begin
              pc_reg <= pc_plus4;
            end
          end
        end
        TRAP: state_reg <= RUN;
        HALT: state_reg <= HALT;
        default: state_reg <= BOOT;
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] taken_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_reg <= 32'h0;
    end else if (commit_next && take_next && !misaligned_next) begin
      taken_cnt_reg <= taken_cnt_reg + 32'd1;
    end
  end

  assign taken_cnt = taken_cnt_reg;
`else
  assign taken_cnt = 32'h0;
`endif

  assign pc       = pc_reg;
  assign bad_addr = bad_addr_reg;
  assign redirect = redirect_reg;
  assign trap     = trap_reg;
  assign halted   = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer plus hand-written HALT/reset/wrap sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branchvalid, jump, jalr, halt_req;
  logic [31:0] imm, rs1_data;
  logic [31:0] pc, pc_plus4, bad_addr, taken_cnt;
  logic        redirect, trap, halted;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branchvalid(branchvalid),
    .jump       (jump),
    .jalr       (jalr),
    .halt_req   (halt_req),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .redirect   (redirect),
    .trap       (trap),
    .bad_addr   (bad_addr),
    .halted     (halted),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, bv, jump, jalr, halt;
    logic [31:0] imm, rs1;
    logic [31:0] e_pc;
    logic        e_redir, e_trap;
    logic [31:0] e_bad;
    logic        e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step%0d: got %h want %h", name, idx, got, want);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef PC_PERF_CNT_EN
    return c;
`else
    return 32'h0 & c;
`endif
  endfunction

  task automatic check_all(input int idx, input logic [31:0] e_pc, input logic e_redir, input logic e_trap,
                           input logic [31:0] e_bad, input logic e_halted, input logic [31:0] e_cnt);
    check("pc", idx, pc, e_pc);
    check("pc_plus4", idx, pc_plus4, e_pc + 32'd4);
    check("redirect", idx, {31'h0, redirect}, {31'h0, e_redir});
    check("trap", idx, {31'h0, trap}, {31'h0, e_trap});
    check("bad_addr", idx, bad_addr, e_bad);
    check("halted", idx, {31'h0, halted}, {31'h0, e_halted});
    check("taken_cnt", idx, taken_cnt, cnt_exp(e_cnt));
    $display("step %0d pc=%h redirect=%b trap=%b bad_addr=%h halted=%b taken_cnt=%0d",
             idx, pc, redirect, trap, bad_addr, halted, taken_cnt);
  endtask

  task automatic drive(input logic s, input logic b, input logic j, input logic jr, input logic h,
                       input logic [31:0] im, input logic [31:0] r);
    stall = s; branchvalid = b; jump = j; jalr = jr; halt_req = h; imm = im; rs1_data = r;
  endtask

  initial begin
    //           stall bv  jump jalr halt imm           rs1           e_pc          redir trap bad           halt cnt
    vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 32'h0,  0, 32'd0}; // BOOT -> RUN
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 32'h0,  0, 32'd0};
    vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0008, 0, 0, 32'h0,  0, 32'd0};
    vecs[3]  = '{0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,       32'h0000_0000, 1, 0, 32'h0,  0, 32'd1};
    vecs[4]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 32'h0,  0, 32'd1};
    vecs[5]  = '{0, 0, 1, 1, 0, 32'h1,        32'h0000_0103, 32'h0000_0104, 1, 0, 32'h0, 0, 32'd2};
    vecs[6]  = '{1, 1, 0, 0, 0, 32'h10,       32'h0,        32'h0000_0104, 0, 0, 32'h0,  0, 32'd2};
    vecs[7]  = '{0, 1, 0, 0, 0, 32'hFFFF_FF0C, 32'h0,       32'h0000_0010, 1, 0, 32'h0,  0, 32'd3};
    vecs[8]  = '{0, 0, 1, 0, 0, 32'h2,        32'h0,        32'h0000_0100, 0, 1, 32'h12, 0, 32'd3};
    vecs[9]  = '{0, 0, 1, 0, 0, 32'h8,        32'h0,        32'h0000_0100, 0, 0, 32'h12, 0, 32'd3}; // TRAP ignores inputs
    vecs[10] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 32'h12, 0, 32'd3};
    vecs[11] = '{0, 0, 0, 1, 0, 32'h3,        32'h0000_001F, 32'h0000_0100, 0, 1, 32'h22, 0, 32'd3};
    vecs[12] = '{0, 1, 0, 0, 0, 32'h4,        32'h0,        32'h0000_0100, 0, 0, 32'h22, 0, 32'd3};
    vecs[13] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 32'h22, 0, 32'd3};
    vecs[14] = '{0, 0, 0, 1, 0, 32'h0,        32'h0000_0021, 32'h0000_0020, 1, 0, 32'h22, 0, 32'd4};
    vecs[15] = '{1, 0, 1, 0, 1, 32'h2,        32'h0,        32'h0000_0020, 0, 0, 32'h22, 1, 32'd4}; // halt beats trap

    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all(100, 32'h0, 0, 0, 32'h0, 0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].bv, vecs[i].jump, vecs[i].jalr, vecs[i].halt, vecs[i].imm, vecs[i].rs1);
      @(posedge clk); #1;
      check_all(i, vecs[i].e_pc, vecs[i].e_redir, vecs[i].e_trap, vecs[i].e_bad, vecs[i].e_halted, vecs[i].e_cnt);
    end

    // HALT: PC frozen regardless of control inputs
    for (int k = 0; k < 10; k++) begin
      drive(k[0], k[1], k[2], k[0] & k[1], ~k[0], 32'h40 + k, 32'h80);
      @(posedge clk); #1;
      check_all(200 + k, 32'h20, 0, 0, 32'h22, 1, 32'd4);
    end

    // Asynchronous reset mid-HALT takes effect before any clock edge
    #2 reset = 1'b1;
    #1;
    check_all(300, 32'h0, 0, 0, 32'h0, 0, 32'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all(301, 32'h0, 0, 0, 32'h0, 0, 32'd0);

    // Redirect to the top of the address space, then sequential wrap to zero
    drive(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
    @(posedge clk); #1;
    check_all(302, 32'hFFFF_FFFC, 1, 0, 32'h0, 0, 32'd1);
    check("pc_plus4_wrap", 302, pc_plus4, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_all(303, 32'h0, 0, 0, 32'h0, 0, 32'd1);
    @(posedge clk); #1;
    check_all(304, 32'h4, 0, 0, 32'h0, 0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
